// File: rtl/switch_set_sched.sv
// rtl/switch_set_sched.sv - switch_set sequencer for a column of 2x2 coefficient switches
module switch_set_sched #(
    parameter int NUM_SW  = 4,
    parameter int CNT_W   = 10,
    parameter int STAGE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [STAGE_W-1:0] cfg_stage,
    input  logic [CNT_W:0]     cfg_beats,
    input  logic [1:0]         cfg_mode,
    input  logic               s_valid,
    output logic [NUM_SW-1:0]  sw_set,
    output logic               m_valid,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [CNT_W:0]      beats_q, beats_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    beat_idx_q, beat_idx_d;
    logic [NUM_SW-1:0]   sw_set_q, sw_set_d;
    logic                err_q, err_d;
    logic [2:0]          vld_q;
    logic [2:0]          lst_q;

    logic                beat_fire;
    logic                last_beat;
    logic [CNT_W-1:0]    idx_shifted;
    logic                idx_bit;
    logic [NUM_SW-1:0]   swap_vec;

    // Swap pattern for the current beat index; a shift past CNT_W yields 0,
    // which covers out-of-range stages without a separate compare.
    always_comb begin
        idx_shifted = beat_idx_q >> stage_q;
        idx_bit     = idx_shifted[0];
        swap_vec    = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            case (mode_q)
                2'b00:   swap_vec[k] = 1'b0;
                2'b01:   swap_vec[k] = idx_bit;
                2'b10:   swap_vec[k] = 1'b1;
                default: swap_vec[k] = idx_bit ^ (k % 2 == 1);
            endcase
        end
    end

    // Next-state logic: config acceptance, beat counting, drain and error flagging.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        beats_d    = beats_q;
        mode_d     = mode_q;
        beat_idx_d = beat_idx_q;
        sw_set_d   = sw_set_q;
        err_d      = err_q;
        beat_fire  = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_beats == '0) begin
                        err_d = 1'b1;
                    end else begin
                        stage_d    = cfg_stage;
                        beats_d    = cfg_beats;
                        mode_d     = cfg_mode;
                        beat_idx_d = '0;
                        err_d      = 1'b0;
                        state_d    = S_RUN;
                    end
                end
                if (s_valid) begin
                    err_d = 1'b1;
                end
            end
            S_RUN: begin
                if (s_valid) begin
                    beat_fire = 1'b1;
                    sw_set_d  = swap_vec;
                    // Counter stops on the last beat, so a full 2^CNT_W pass never wraps.
                    if ({1'b0, beat_idx_q} == beats_q - (CNT_W+1)'(1)) begin
                        last_beat = 1'b1;
                        state_d   = S_DRAIN;
                    end else begin
                        beat_idx_d = beat_idx_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (s_valid) begin
                    err_d = 1'b1;
                end
                if (vld_q[2] && lst_q[2]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, configuration and switch-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            beats_q    <= '0;
            mode_q     <= '0;
            beat_idx_q <= '0;
            sw_set_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            beats_q    <= beats_d;
            mode_q     <= mode_d;
            beat_idx_q <= beat_idx_d;
            sw_set_q   <= sw_set_d;
            err_q      <= err_d;
        end
    end

    // Valid/last shadow of the 3-cycle switch pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[1:0], beat_fire};
            lst_q <= {lst_q[1:0], last_beat};
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign sw_set    = sw_set_q;
    assign m_valid   = vld_q[2];
    assign m_last    = vld_q[2] & lst_q[2];
    assign done      = vld_q[2] & lst_q[2];
    assign err       = err_q;

endmodule
